// File: rtl/seq_left_rotator_if.sv
// seq_left_rotator_if
//   Request/result bundle for seq_left_rotator.
//   Parameter N: log2 of data width (W = 2**N).
//   Signals:
//     start   request, accepted when busy=0
//     a       W-bit operand, sampled on the accepting edge
//     amt     N-bit left amount, sampled on the accepting edge
//     logical 1=zero-fill shift, 0=rotate (present only with LOGICAL_SHIFT_EN)
//     y       W-bit registered result
//     busy    high while an operation is in flight (SHIFT/DONE)
//     done    one-cycle pulse when y is new
//   Modports: master drives the request, slave (the rotator) drives the result.
//   Optional feature macro: LOGICAL_SHIFT_EN
interface seq_left_rotator_if #(
  parameter int N = 4
);
  localparam int W = 1 << N;

  logic         start;
  logic [W-1:0] a;
  logic [N-1:0] amt;
`ifdef LOGICAL_SHIFT_EN
  logic         logical;
`endif
  logic [W-1:0] y;
  logic         busy;
  logic         done;

`ifdef LOGICAL_SHIFT_EN
  modport master (output start, a, amt, logical, input y, busy, done);
  modport slave  (input start, a, amt, logical, output y, busy, done);
`else
  modport master (output start, a, amt, input y, busy, done);
  modport slave  (input start, a, amt, output y, busy, done);
`endif
endinterface

// File: rtl/seq_left_rotator.sv
// seq_left_rotator
//   Multi-cycle left barrel rotator: one bit position per clock, registered
//   result and a one-cycle done pulse. Trades latency for area.
//   Parameter N: log2 of data width (W = 2**N), amount width N.
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous active-high reset; aborts an in-flight operation
//     bus    seq_left_rotator_if.slave (start/a/amt[/logical] in, y/busy/done out)
//   Optional feature macro: LOGICAL_SHIFT_EN (adds zero-fill shift mode,
//   selected by bus.logical latched at acceptance).
module seq_left_rotator #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_left_rotator_if.slave    bus
);
  localparam int W = 1 << N;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_work;
  logic [N-1:0] r_cnt;
  logic [W-1:0] r_y;
  logic         r_busy;
  logic         r_done;
  logic [W-1:0] w_step;

`ifdef LOGICAL_SHIFT_EN
  logic         r_logical;

  always_comb begin
    w_step = {r_work[W-2:0], r_work[W-1]};
    if (r_logical) begin
      w_step = {r_work[W-2:0], 1'b0};
    end
  end
`else
  always_comb begin
    w_step = {r_work[W-2:0], r_work[W-1]};
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_work    <= '0;
      r_cnt     <= '0;
      r_y       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef LOGICAL_SHIFT_EN
      r_logical <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_work <= bus.a;
            r_cnt  <= bus.amt;
            r_busy <= 1'b1;
`ifdef LOGICAL_SHIFT_EN
            r_logical <= bus.logical;
`endif
            // Zero amount completes immediately so done follows acceptance by one cycle.
            if (bus.amt == '0) begin
              r_y     <= bus.a;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_work <= w_step;
          r_cnt  <= r_cnt - 1'b1;
          // The last step writes the result directly, so y lands with the DONE entry.
          if (r_cnt == {{(N-1){1'b0}}, 1'b1}) begin
            r_y     <= w_step;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.y    = r_y;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule
